// File: rtl/map_tile_renderer_pkg.sv
// Shared definitions for the map display path: cell codes, palette and renderer states.
// The sprite renderer uses the same cell codes and palette.
package map_pkg;

    localparam int CELL_EMPTY  = 0;
    localparam int CELL_WALL   = 1;
    localparam int CELL_PELLET = 2;
    localparam int CELL_POWER  = 3;

    localparam logic [2:0] COL_BLACK   = 3'b000;
    localparam logic [2:0] COL_BLUE    = 3'b001;
    localparam logic [2:0] COL_WHITE   = 3'b111;
    localparam logic [2:0] COL_YELLOW  = 3'b110;
    localparam logic [2:0] COL_MAGENTA = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DRAW,
        ST_NEXT
    } state_t;

endpackage

// File: rtl/map_tile_renderer_if.sv
// Signal bundle between the tile renderer, the game logic, the MapController read port
// and the vga_adapter plot port.
interface map_tile_renderer_if #(
    parameter int GX_W      = 5,
    parameter int GY_W      = 4,
    parameter int CELL_BITS = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
);
    logic                 frame_tick;
    logic                 cell_req;
    logic [GX_W-1:0]      cell_req_x;
    logic [GY_W-1:0]      cell_req_y;
    logic                 cell_ack;
    logic                 map_rd;
    logic [GX_W-1:0]      map_x;
    logic [GY_W-1:0]      map_y;
    logic [CELL_BITS-1:0] map_data;
    logic [X_W-1:0]       vga_x;
    logic [Y_W-1:0]       vga_y;
    logic [2:0]           vga_colour;
    logic                 vga_plot;
    logic                 busy;
    logic                 frame_done;
    logic [7:0]           overrun_count;

    modport slave (
        input  frame_tick, cell_req, cell_req_x, cell_req_y, map_data,
        output cell_ack, map_rd, map_x, map_y, vga_x, vga_y, vga_colour, vga_plot,
               busy, frame_done, overrun_count
    );

    modport master (
        output frame_tick, cell_req, cell_req_x, cell_req_y, map_data,
        input  cell_ack, map_rd, map_x, map_y, vga_x, vga_y, vga_colour, vga_plot,
               busy, frame_done, overrun_count
    );

endinterface

// File: rtl/map_tile_renderer_lut.sv
// Combinational tile palette: maps a cell code and a pixel offset inside the tile to a colour.
module tile_colour_lut
    import map_pkg::*;
#(
    parameter int TILE      = 8,
    parameter int CELL_BITS = 2,
    parameter int PX_W      = $clog2(TILE)
) (
    input  logic [CELL_BITS-1:0] code,
    input  logic [PX_W-1:0]      px,
    input  logic [PX_W-1:0]      py,
    output logic [2:0]           colour
);

    localparam logic [PX_W-1:0] HALF = PX_W'(TILE / 2);
    localparam logic [PX_W-1:0] EDGE = PX_W'(TILE - 2);

    // Pellet is a single centre dot; the power pellet fills everything but a 1-pixel border.
    always_comb begin
        colour = COL_BLACK;
        if (code == CELL_BITS'(CELL_EMPTY)) begin
            colour = COL_BLACK;
        end else if (code == CELL_BITS'(CELL_WALL)) begin
            colour = COL_BLUE;
        end else if (code == CELL_BITS'(CELL_PELLET)) begin
            if (px == HALF && py == HALF)
                colour = COL_WHITE;
        end else if (code == CELL_BITS'(CELL_POWER)) begin
            if (px != '0 && py != '0 && px <= EDGE && py <= EDGE)
                colour = COL_YELLOW;
        end else begin
            colour = COL_MAGENTA;
        end
    end

endmodule

// File: rtl/map_tile_renderer.sv
// Walks the tile map and expands each cell into a TILE x TILE pixel block, either for a
// whole frame on frame_tick or for one cell on a cell_req/cell_ack handshake.
module map_tile_renderer
    import map_pkg::*;
#(
    parameter int GRID_W    = 20,
    parameter int GRID_H    = 15,
    parameter int TILE      = 8,
    parameter int CELL_BITS = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int GX_W      = 5,
    parameter int GY_W      = 4
) (
    input  logic                clock_50,
    input  logic                resetn,
    map_tile_renderer_if.slave  bus
);

    localparam int              PX_W   = $clog2(TILE);
    localparam logic [GX_W-1:0] LAST_X = GX_W'(GRID_W - 1);
    localparam logic [GY_W-1:0] LAST_Y = GY_W'(GRID_H - 1);
    localparam logic [PX_W-1:0] LAST_P = PX_W'(TILE - 1);

    state_t               state;
    state_t               state_next;
    logic                 full_mode;
    logic [GX_W-1:0]      cx;
    logic [GY_W-1:0]      cy;
    logic [PX_W-1:0]      px;
    logic [PX_W-1:0]      py;
    logic [CELL_BITS-1:0] cell_q;
    logic [2:0]           pix_colour;
    logic                 in_range;
    logic                 last_cell;
    logic                 last_pixel;

    assign in_range   = (cx <= LAST_X) && (cy <= LAST_Y);
    assign last_cell  = (cx == LAST_X) && (cy == LAST_Y);
    assign last_pixel = (px == LAST_P) && (py == LAST_P);
    assign bus.map_x  = cx;
    assign bus.map_y  = cy;

    tile_colour_lut #(
        .TILE      (TILE),
        .CELL_BITS (CELL_BITS),
        .PX_W      (PX_W)
    ) u_lut (
        .code   (cell_q),
        .px     (px),
        .py     (py),
        .colour (pix_colour)
    );

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // An out-of-range single request is detected once its coordinates are latched and
    // skips straight to NEXT, so it acks without touching the map or the screen.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (bus.frame_tick || bus.cell_req) state_next = ST_FETCH;
            ST_FETCH: state_next = in_range ? ST_WAIT : ST_NEXT;
            ST_WAIT:  state_next = ST_DRAW;
            ST_DRAW:  if (last_pixel) state_next = ST_NEXT;
            ST_NEXT:  state_next = (full_mode && !last_cell) ? ST_FETCH : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.map_rd     = (state == ST_FETCH) && in_range;
        bus.cell_ack   = (state == ST_NEXT) && !full_mode;
        bus.frame_done = (state == ST_NEXT) && full_mode && last_cell;
        bus.busy       = (state != ST_IDLE);
    end

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            full_mode <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            px        <= '0;
            py        <= '0;
            cell_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.frame_tick) begin
                        full_mode <= 1'b1;
                        cx        <= '0;
                        cy        <= '0;
                    end else if (bus.cell_req) begin
                        full_mode <= 1'b0;
                        cx        <= bus.cell_req_x;
                        cy        <= bus.cell_req_y;
                    end
                end
                ST_WAIT: begin
                    cell_q <= bus.map_data;
                    px     <= '0;
                    py     <= '0;
                end
                ST_DRAW: begin
                    px <= px + 1'b1;
                    if (px == LAST_P)
                        py <= py + 1'b1;
                end
                ST_NEXT: begin
                    if (full_mode) begin
                        if (cx == LAST_X) begin
                            cx <= '0;
                            cy <= last_cell ? '0 : cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel outputs are registered, so each plot appears one cycle after its DRAW cycle.
    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn) begin
            bus.vga_plot   <= 1'b0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
        end else begin
            bus.vga_plot   <= (state == ST_DRAW);
            bus.vga_x      <= (state == ST_DRAW) ? ((X_W'(cx) << PX_W) | X_W'(px)) : '0;
            bus.vga_y      <= (state == ST_DRAW) ? ((Y_W'(cy) << PX_W) | Y_W'(py)) : '0;
            bus.vga_colour <= (state == ST_DRAW) ? pix_colour : '0;
        end
    end

    always_ff @(posedge clock_50 or negedge resetn) begin
        if (!resetn)
            bus.overrun_count <= 8'd0;
        else if ((state != ST_IDLE) && bus.frame_tick && (bus.overrun_count != 8'hFF))
            bus.overrun_count <= bus.overrun_count + 8'd1;
    end

endmodule

// File: tb/tb_map_tile_renderer.sv
// Directed bench for map_tile_renderer on a 2x2 map of 2x2 tiles holding codes {0,1,2,3};
// expected plots go into a scoreboard queue and are matched against recorded plots.
module tb_map_tile_renderer;

    localparam int GRID_W = 2;
    localparam int GRID_H = 2;
    localparam int TILE   = 2;
    localparam int OBS_N  = 4096;

    logic clock_50 = 1'b0;
    logic resetn   = 1'b0;

    map_tile_renderer_if #(.GX_W(5), .GY_W(4), .CELL_BITS(2), .X_W(8), .Y_W(7)) bus ();

    map_tile_renderer #(
        .GRID_W (GRID_W), .GRID_H (GRID_H), .TILE (TILE), .CELL_BITS (2),
        .X_W (8), .Y_W (7), .GX_W (5), .GY_W (4)
    ) dut (
        .clock_50 (clock_50),
        .resetn   (resetn),
        .bus      (bus)
    );

    always #5 clock_50 = ~clock_50;

    int cyc = 0;
    always @(posedge clock_50) cyc <= cyc + 1;

    logic [1:0] map_mem [0:3] = '{2'd0, 2'd1, 2'd2, 2'd3};

    always @(posedge clock_50) begin
        if (bus.map_rd && (int'(bus.map_y) * GRID_W + int'(bus.map_x)) < 4)
            bus.map_data <= map_mem[int'(bus.map_y) * GRID_W + int'(bus.map_x)];
    end

    // Recorder: everything the DUT produces, sampled on the falling edge.
    logic [31:0] obs_mem [OBS_N];
    int obs_wr = 0;
    int rd_cnt = 0;
    int ack_cnt = 0;
    int done_cnt = 0;
    int ack_cyc = 0;
    int done_cyc = 0;
    int last_rd_x = 0;
    int last_rd_y = 0;

    always @(negedge clock_50) begin
        if (resetn) begin
            if (bus.vga_plot && obs_wr < OBS_N) begin
                obs_mem[obs_wr] = 32'({bus.vga_x, bus.vga_y, bus.vga_colour});
                obs_wr++;
            end
            if (bus.map_rd) begin
                rd_cnt++;
                last_rd_x = int'(bus.map_x);
                last_rd_y = int'(bus.map_y);
            end
            if (bus.cell_ack) begin
                ack_cnt++;
                ack_cyc = cyc;
            end
            if (bus.frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int obs_rd = 0;
    int idle_cyc = 0;
    logic [31:0] exp_q [$];

    task automatic check_output(string tag, logic [63:0] observed, logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [2:0] ref_colour(int code, int px, int py);
        case (code)
            0: return 3'b000;
            1: return 3'b001;
            2: return (px == TILE / 2 && py == TILE / 2) ? 3'b111 : 3'b000;
            3: return (px >= 1 && px <= TILE - 2 && py >= 1 && py <= TILE - 2) ? 3'b110 : 3'b000;
            default: return 3'b101;
        endcase
    endfunction

    task automatic push_cell(int cx, int cy);
        int code;
        code = int'(map_mem[cy * GRID_W + cx]);
        for (int py = 0; py < TILE; py++) begin
            for (int px = 0; px < TILE; px++) begin
                exp_q.push_back(32'({8'(cx * TILE + px), 7'(cy * TILE + py), ref_colour(code, px, py)}));
            end
        end
    endtask

    task automatic push_frame();
        for (int cy = 0; cy < GRID_H; cy++)
            for (int cx = 0; cx < GRID_W; cx++)
                push_cell(cx, cy);
    endtask

    task automatic compare_plots(string tag);
        check_output({tag, "_plot_count"}, 64'(obs_wr - obs_rd), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_rd < obs_wr) begin
            check_output({tag, "_pixel"}, 64'(obs_mem[obs_rd]), 64'(exp_q.pop_front()));
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_wr;
    endtask

    task automatic wait_idle(string tag);
        int n;
        n = 0;
        do begin
            @(negedge clock_50);
            bus.frame_tick = 1'b0;
            if (bus.cell_ack)
                bus.cell_req = 1'b0;
            n++;
        end while ((bus.busy || bus.cell_req) && n < 400);
        #1;
        idle_cyc = cyc;
        if (n >= 400)
            check_output({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.cell_ack, bus.map_rd, bus.map_x, bus.map_y, bus.vga_x, bus.vga_y,
                    bus.vga_colour, bus.vga_plot, bus.busy, bus.frame_done, bus.overrun_count});
    endfunction

    task automatic apply_stimulus(logic tick, logic req, int x, int y, output int c0);
        bus.frame_tick = tick;
        bus.cell_req   = req;
        bus.cell_req_x = 5'(x);
        bus.cell_req_y = 4'(y);
        c0 = cyc;
    endtask

    initial begin
        int c0;
        int snap_rd;
        int snap_ack;
        int snap_done;
        int snap_obs;

        bus.frame_tick = 1'b0;
        bus.cell_req   = 1'b0;
        bus.cell_req_x = '0;
        bus.cell_req_y = '0;

        // Reset state
        repeat (3) @(negedge clock_50);
        check_output("reset_outputs", all_outputs(), 64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clock_50);

        // 1: full frame
        $display("[TB] full frame");
        snap_rd = rd_cnt; snap_ack = ack_cnt; snap_done = done_cnt;
        apply_stimulus(1'b1, 1'b0, 0, 0, c0);
        push_frame();
        wait_idle("frame1");
        compare_plots("frame1");
        check_output("frame1_done_pulses", 64'(done_cnt - snap_done), 64'd1);
        check_output("frame1_done_cycle", 64'(done_cyc - c0), 64'd28);
        check_output("frame1_no_ack", 64'(ack_cnt - snap_ack), 64'd0);
        check_output("frame1_map_reads", 64'(rd_cnt - snap_rd), 64'd4);
        check_output("frame1_overrun", 64'(bus.overrun_count), 64'd0);

        // 2: single cell (1,0)
        $display("[TB] single cell");
        snap_rd = rd_cnt; snap_ack = ack_cnt;
        apply_stimulus(1'b0, 1'b1, 1, 0, c0);
        push_cell(1, 0);
        wait_idle("cell10");
        compare_plots("cell10");
        check_output("cell10_map_reads", 64'(rd_cnt - snap_rd), 64'd1);
        check_output("cell10_map_x", 64'(last_rd_x), 64'd1);
        check_output("cell10_map_y", 64'(last_rd_y), 64'd0);
        check_output("cell10_ack_pulses", 64'(ack_cnt - snap_ack), 64'd1);
        check_output("cell10_ack_cycle", 64'(ack_cyc - c0), 64'd7);
        check_output("cell10_idle_after_ack", 64'(idle_cyc - ack_cyc), 64'd1);

        // 3: tick and request together; frame first, then the cell
        $display("[TB] tick and request together");
        snap_ack = ack_cnt; snap_done = done_cnt;
        apply_stimulus(1'b1, 1'b1, 0, 1, c0);
        push_frame();
        push_cell(0, 1);
        wait_idle("both");
        compare_plots("both");
        check_output("both_done_pulses", 64'(done_cnt - snap_done), 64'd1);
        check_output("both_ack_pulses", 64'(ack_cnt - snap_ack), 64'd1);
        check_output("both_ack_cycle", 64'(ack_cyc - c0), 64'd36);

        // 4: ticks while busy are dropped and counted
        $display("[TB] overrun");
        snap_done = done_cnt;
        apply_stimulus(1'b1, 1'b0, 0, 0, c0);
        push_frame();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock_50);
            bus.frame_tick = (k == 5 || k == 12 || k == 28);
        end
        wait_idle("overrun");
        compare_plots("overrun");
        check_output("overrun_done_pulses", 64'(done_cnt - snap_done), 64'd1);
        check_output("overrun_three", 64'(bus.overrun_count), 64'd3);
        bus.frame_tick = 1'b1;
        repeat (320) @(negedge clock_50);
        wait_idle("saturate");
        obs_rd = obs_wr;
        check_output("overrun_saturated", 64'(bus.overrun_count), 64'd255);

        // 5: out-of-range request
        $display("[TB] out-of-range request");
        snap_rd = rd_cnt; snap_ack = ack_cnt; snap_obs = obs_wr;
        apply_stimulus(1'b0, 1'b1, 3, 0, c0);
        wait_idle("oor");
        check_output("oor_ack_pulses", 64'(ack_cnt - snap_ack), 64'd1);
        check_output("oor_ack_cycle", 64'(ack_cyc - c0), 64'd2);
        check_output("oor_map_reads", 64'(rd_cnt - snap_rd), 64'd0);
        check_output("oor_plots", 64'(obs_wr - snap_obs), 64'd0);

        // 6: reset in the middle of a single-cell draw
        $display("[TB] reset mid-draw");
        apply_stimulus(1'b0, 1'b1, 1, 1, c0);
        repeat (4) @(negedge clock_50);
        check_output("mid_draw_busy", 64'(bus.busy), 64'd1);
        #1 resetn = 1'b0;
        #1 check_output("async_reset_outputs", all_outputs(), 64'd0);
        bus.cell_req = 1'b0;
        snap_ack = ack_cnt;
        repeat (2) @(negedge clock_50);
        resetn = 1'b1;
        repeat (10) @(negedge clock_50);
        check_output("post_reset_no_ack", 64'(ack_cnt - snap_ack), 64'd0);
        check_output("post_reset_idle", 64'(bus.busy), 64'd0);
        obs_rd = obs_wr;
        snap_done = done_cnt;
        apply_stimulus(1'b1, 1'b0, 0, 0, c0);
        push_frame();
        wait_idle("frame2");
        compare_plots("frame2");
        check_output("frame2_done_pulses", 64'(done_cnt - snap_done), 64'd1);
        check_output("frame2_done_cycle", 64'(done_cyc - c0), 64'd28);
        check_output("frame2_overrun", 64'(bus.overrun_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
